hoaa_adder_pipe: RTL and testbench

- Parametrised N-bit hybrid OR-approximate adder (HOAA) with a valid/ready handshake and a STAGES-deep stallable pipeline.
- The low APPROX_BITS bits use the approximate cell:
  - sum_i = a_i | ~(b_i ^ c_i)
  - c_{i+1} = b_i | c_i
- The upper bits are exact ripple-carry bits.
- Per transaction, the block can run in exact or approximate mode.
- A built-in error monitor counts approximate results that differ from the exact result, for accuracy characterisation in the adder test harness.

---
 rtl/hoaa_pkg.sv | 47 ++++
 rtl/hoaa_adder_pipe_comb.sv | 35 +++
 rtl/hoaa_adder_pipe.sv | 102 ++++++++++
 tb/tb_hoaa_adder_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hoaa_pkg.sv
// Shared constants and the bit-serial HOAA reference function for the
// hybrid OR-approximate adder.
package hoaa_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Widest operand the reference function handles.
  localparam int HOAA_MAX_W = 64;

  // Result is {cout, sum}: sum in bits [width-1:0], carry out at bit width,
  // all bits above width are zero. Bits below approx_bits use the OR cell.
  function automatic logic [HOAA_MAX_W:0] hoaa_ref(
    input logic [HOAA_MAX_W-1:0] a,
    input logic [HOAA_MAX_W-1:0] b,
    input logic                  cin,
    input int                    width,
    input int                    approx_bits
  );
    logic [HOAA_MAX_W:0]   r;
    logic [HOAA_MAX_W-1:0] aa;
    logic [HOAA_MAX_W-1:0] bb;
    logic                  c;
    logic                  s;
    r  = '0;
    aa = a;
    bb = b;
    c  = cin;
    for (int i = 0; i < HOAA_MAX_W; i++) begin
      if (i < width) begin
        if (i < approx_bits) begin
          s = aa[0] | ~(bb[0] ^ c);
          c = bb[0] | c;
        end else begin
          s = aa[0] ^ bb[0] ^ c;
          c = (aa[0] & bb[0]) | (c & (aa[0] ^ bb[0]));
        end
        r = r | ({{HOAA_MAX_W{1'b0}}, s} << i);
      end
      aa = aa >> 1;
      bb = bb >> 1;
    end
    r = r | ({{HOAA_MAX_W{1'b0}}, c} << width);
    return r;
  endfunction

endpackage

// File: rtl/hoaa_adder_pipe_comb.sv
// Combinational HOAA / exact adder with a parallel exact reference and
// mismatch flag.
module hoaa_comb
  import hoaa_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             approx_en_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             mismatch_o
);

  localparam int RW = WIDTH + 1;

  logic [WIDTH:0] apx;
  logic [WIDTH:0] exa;

  always_comb begin
    apx = RW'(hoaa_ref(HOAA_MAX_W'(a_i), HOAA_MAX_W'(b_i), cin_i, WIDTH, APPROX_BITS));
    exa = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    if (approx_en_i == MODE_APPROX) begin
      {cout_o, sum_o} = apx;
      mismatch_o      = (apx != exa);
    end else begin
      {cout_o, sum_o} = exa;
      mismatch_o      = 1'b0;
    end
  end

endmodule

// File: rtl/hoaa_adder_pipe.sv
// Stallable STAGES-deep pipeline around the HOAA adder, with a saturating
// counter of mismatching results accepted downstream.
module hoaa_adder_pipe
  import hoaa_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4,
  parameter int STAGES      = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             mismatch,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             en;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             mm_d;

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] cout_q;
  logic [STAGES-1:0] mm_q;

  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  hoaa_comb #(
    .WIDTH      (WIDTH),
    .APPROX_BITS(APPROX_BITS)
  ) u_comb (
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
    .approx_en_i(approx_en),
    .sum_o      (sum_d),
    .cout_o     (cout_d),
    .mismatch_o (mm_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cout_q <= '0;
      mm_q   <= '0;
      for (int s = 0; s < STAGES; s++) sum_q[s] <= '0;
    end else if (en) begin
      vld_q[0]  <= in_valid & in_ready;
      sum_q[0]  <= sum_d;
      cout_q[0] <= cout_d;
      mm_q[0]   <= mm_d;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s]  <= vld_q[s-1];
        sum_q[s]  <= sum_q[s-1];
        cout_q[s] <= cout_q[s-1];
        mm_q[s]   <= mm_q[s-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = cout_q[STAGES-1];
  assign mismatch  = mm_q[STAGES-1];

  // Clear has priority over a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (out_valid && out_ready && mismatch && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_hoaa_adder_pipe.sv
// Directed bench for hoaa_adder_pipe (WIDTH=8, APPROX_BITS=2, STAGES=2);
// a second instance with a 2-bit counter exercises saturation.
module tb_hoaa_adder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       approx_en;
  logic       out_ready;
  logic       err_clr;

  logic        in_ready, out_valid, cout, mismatch;
  logic [7:0]  sum;
  logic [15:0] err_cnt;

  logic       s_in_ready, s_out_valid, s_cout, s_mismatch;
  logic [7:0] s_sum;
  logic [1:0] s_err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hoaa_adder_pipe #(.WIDTH(8), .APPROX_BITS(2), .STAGES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .mismatch(mismatch), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  hoaa_adder_pipe #(.WIDTH(8), .APPROX_BITS(2), .STAGES(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .cin(cin), .approx_en(approx_en),
    .out_valid(s_out_valid), .out_ready(out_ready), .sum(s_sum), .cout(s_cout),
    .mismatch(s_mismatch), .err_clr(err_clr), .err_cnt(s_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic tm);
    a = ta; b = tb; cin = tc; approx_en = tm; in_valid = 1'b1;
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic tm);
    drive(ta, tb, tc, tm);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic result(input string tag, input logic [7:0] es, input logic ec, input logic em);
    tick();
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_mm"}, mismatch, em);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    approx_en = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    #2;
    chk("rst_vld", out_valid, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_vld", out_valid, 0);

    // Latency and the basic approximate example
    send(8'h00, 8'h00, 1'b0, 1'b1);
    chk("lat1_vld", out_valid, 0);
    result("apx00", 8'h03, 1'b0, 1'b1);
    chk("apx00_cnt_pre", err_cnt, 0);
    tick();
    chk("apx00_cnt", err_cnt, 1);
    chk("apx00_drain", out_valid, 0);

    send(8'h03, 8'h00, 1'b0, 1'b1);  result("apx03", 8'h03, 1'b0, 1'b0);
    send(8'h03, 8'h00, 1'b0, 1'b0);  result("exa03", 8'h03, 1'b0, 1'b0);
    send(8'h0F, 8'h01, 1'b1, 1'b1);  result("apxcy", 8'h13, 1'b0, 1'b1);
    send(8'h0F, 8'h01, 1'b1, 1'b0);  result("exacy", 8'h11, 1'b0, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 1'b0);  result("exaovf", 8'h00, 1'b1, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 1'b1);  result("apxovf", 8'h03, 1'b1, 1'b1);
    tick();
    chk("cnt3", err_cnt, 3);
    chk("sat_cnt3", s_err_cnt, 3);

    // Back-to-back stream with a 3-cycle stall
    drive(8'h00, 8'h00, 1'b0, 1'b1); tick();
    drive(8'h03, 8'h00, 1'b0, 1'b1); tick();
    chk("bp_v0_vld", out_valid, 1);
    chk("bp_v0_mm", mismatch, 1);
    drive(8'h0F, 8'h01, 1'b1, 1'b1);
    out_ready = 1'b0;
    #1;
    chk("bp_rdy_lo", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_sum", sum, 8'h03);
      chk("bp_hold_mm", mismatch, 1);
      chk("bp_hold_rdy", in_ready, 0);
      chk("bp_hold_cnt", err_cnt, 3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_hi", in_ready, 1);
    tick();
    chk("bp_v1_vld", out_valid, 1);
    chk("bp_v1_sum", sum, 8'h03);
    chk("bp_v1_mm", mismatch, 0);
    drive(8'h10, 8'h20, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("bp_v2_sum", sum, 8'h13);
    chk("bp_v2_mm", mismatch, 1);
    tick();
    chk("bp_v3_vld", out_valid, 1);
    chk("bp_v3_sum", sum, 8'h30);
    chk("bp_v3_mm", mismatch, 0);
    tick();
    chk("bp_end_vld", out_valid, 0);
    chk("bp_cnt5", err_cnt, 5);
    chk("sat_hold", s_err_cnt, 3);

    // Clear wins over a same-cycle mismatching handshake
    send(8'h00, 8'h00, 1'b0, 1'b1);
    result("clrmm", 8'h03, 1'b0, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_cnt", err_cnt, 0);
    chk("clr_sat", s_err_cnt, 0);

    // Asynchronous reset in the middle of a stream
    drive(8'h00, 8'h00, 1'b0, 1'b1); tick();
    drive(8'h03, 8'h00, 1'b0, 1'b1); tick();
    in_valid = 1'b0;
    chk("mid_v0_mm", mismatch, 1);
    tick();
    chk("mid_cnt", err_cnt, 1);
    chk("mid_vld", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", out_valid, 0);
    chk("arst_cnt", err_cnt, 0);
    chk("arst_sum", sum, 0);
    chk("arst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_vld1", out_valid, 0);
    tick();
    chk("post_vld2", out_valid, 0);
    chk("post_cnt", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
